axis_demux_sched: RTL and testbench

- Sequencing controller for the 3-way AXI-Stream demultiplexer in the correlation datapath.
- Drives the demux select and gates the demux input handshake.
- Routes a programmed number of beats to output 1, then output 2, then output 3, in single-shot or continuous mode.
- Sits inline on the demux input stream: upstream source, then this block, then the demux indata port.

---
 rtl/axis_demux_sched.sv | 148 ++++++++++++++
 tb/tb_axis_demux_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/axis_demux_sched.sv
// Sequencer for a 3-way AXIS demux: routes len_1/len_2/len_3 beats to outputs 1/2/3, one-shot or continuous.
// Zero-latency combinational handshake gating; demux_sel/busy/done registered; frame counter under AXIS_DEMUX_SCHED_FRAME_CNT_EN.
`timescale 1ns/1ps
module axis_demux_sched #(
  parameter int CNT_W  = 16,
  parameter int FCNT_W = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  input  logic             cont_mode,
  input  logic [CNT_W-1:0] len_1,
  input  logic [CNT_W-1:0] len_2,
  input  logic [CNT_W-1:0] len_3,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [1:0]       demux_sel,
  output logic             busy,
  output logic             done
`ifdef AXIS_DEMUX_SCHED_FRAME_CNT_EN
  ,
  output logic [FCNT_W-1:0] frame_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, R1, R2, R3} state_t;

  state_t           state, nxt, route_nxt;
  logic [CNT_W-1:0] cnt, cur_len;
  logic [CNT_W-1:0] l1, l2, l3;
  logic             cmode, stop_req;
  logic             active, hs, last_beat, seq_end, done_nxt;

  function automatic state_t first_nz(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b,
                                      input logic [CNT_W-1:0] c);
    state_t r;
    if (a != '0)      r = R1;
    else if (b != '0) r = R2;
    else if (c != '0) r = R3;
    else              r = IDLE;
    return r;
  endfunction

  // Route following s that still has beats to carry; IDLE means s ends the sequence.
  function automatic state_t after(input state_t s, input logic [CNT_W-1:0] b,
                                   input logic [CNT_W-1:0] c);
    state_t r;
    case (s)
      R1:      r = (b != '0) ? R2 : ((c != '0) ? R3 : IDLE);
      R2:      r = (c != '0) ? R3 : IDLE;
      default: r = IDLE;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sel_of(input state_t s);
    logic [1:0] r;
    case (s)
      R2:      r = 2'b01;
      R3:      r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign active   = (state != IDLE);
  assign m_tvalid = active & s_tvalid;
  assign s_tready = active & m_tready;
  assign hs       = active & s_tvalid & m_tready;

  always_comb begin
    cur_len = '0;
    case (state)
      R1:      cur_len = l1;
      R2:      cur_len = l2;
      R3:      cur_len = l3;
      default: cur_len = '0;
    endcase
  end

  assign last_beat = hs && (cnt == cur_len - CNT_W'(1));
  assign route_nxt = after(state, l2, l3);
  assign seq_end   = last_beat && (route_nxt == IDLE);

  always_comb begin
    nxt      = state;
    done_nxt = 1'b0;
    if (abort) begin
      nxt = IDLE;
    end else if (state == IDLE) begin
      if (start) begin
        nxt      = first_nz(len_1, len_2, len_3);
        done_nxt = (nxt == IDLE);
      end
    end else if (last_beat) begin
      done_nxt = seq_end;
      if (!seq_end)                      nxt = route_nxt;
      // A stop landing on the final beat still ends this sequence.
      else if (cmode && !(stop_req || stop)) nxt = first_nz(l1, l2, l3);
      else                               nxt = IDLE;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= IDLE;
      demux_sel <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      stop_req  <= 1'b0;
      l1        <= '0;
      l2        <= '0;
      l3        <= '0;
      cmode     <= 1'b0;
`ifdef AXIS_DEMUX_SCHED_FRAME_CNT_EN
      frame_cnt <= '0;
`endif
    end else begin
      state     <= nxt;
      demux_sel <= sel_of(nxt);
      busy      <= (nxt != IDLE);
      done      <= done_nxt;
`ifdef AXIS_DEMUX_SCHED_FRAME_CNT_EN
      if (done_nxt) frame_cnt <= frame_cnt + FCNT_W'(1);
`endif
      if (abort) begin
        cnt      <= '0;
        stop_req <= 1'b0;
      end else if (state == IDLE && start) begin
        l1       <= len_1;
        l2       <= len_2;
        l3       <= len_3;
        cmode    <= cont_mode;
        stop_req <= stop;
        cnt      <= '0;
      end else begin
        if (stop) stop_req <= 1'b1;
        if (hs)   cnt <= last_beat ? '0 : cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_demux_sched.sv
// Randomized bench for axis_demux_sched against a beat-list reference model.
`timescale 1ns/1ps
module tb_axis_demux_sched;
  localparam int CNT_W  = 16;
  localparam int FCNT_W = 16;

  logic             aclk = 1'b0;
  logic             areset;
  logic             start, stop, abort, cont_mode;
  logic [CNT_W-1:0] len_1, len_2, len_3;
  logic             s_tvalid, s_tready, m_tvalid, m_tready;
  logic [1:0]       demux_sel;
  logic             busy, done;
`ifdef AXIS_DEMUX_SCHED_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int frame_exp = 0;

  axis_demux_sched #(.CNT_W(CNT_W), .FCNT_W(FCNT_W)) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop), .abort(abort),
    .cont_mode(cont_mode), .len_1(len_1), .len_2(len_2), .len_3(len_3),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .demux_sel(demux_sel), .busy(busy), .done(done)
`ifdef AXIS_DEMUX_SCHED_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frames();
`ifdef AXIS_DEMUX_SCHED_FRAME_CNT_EN
    chk("frame_cnt", 32'(frame_cnt), 32'(frame_exp));
`endif
  endtask

  // One sequence run. rmode: 0 ready=1, 1 toggle, 2 random. vmode: 0 valid=1, 1 random.
  // nseq: sequences expected in continuous mode before stop takes effect.
  task automatic run(input int a, input int b, input int c, input bit cm, input int nseq,
                     input int rmode, input int vmode, input int abort_at, input int reset_at);
    logic [1:0] rt[$];
    int  seqlen, total, idx, cyc;
    bit  pend, stop_sent;
    seqlen = a + b + c;
    rt = {};
    for (int s = 0; s < (cm ? nseq : 1); s++) begin
      for (int i = 0; i < a; i++) rt.push_back(2'b00);
      for (int i = 0; i < b; i++) rt.push_back(2'b01);
      for (int i = 0; i < c; i++) rt.push_back(2'b10);
    end
    total = rt.size();

    @(posedge aclk); #1;
    len_1 = CNT_W'(a); len_2 = CNT_W'(b); len_3 = CNT_W'(c);
    cont_mode = cm; start = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1; stop = 1'b0;
    @(negedge aclk);
    chk("start_idle_busy", 32'(busy), 0);
    chk("start_idle_mtvalid", 32'(m_tvalid), 0);
    chk("start_idle_stready", 32'(s_tready), 0);
    @(posedge aclk); #1;
    start = 1'b0;
    len_1 = CNT_W'($urandom_range(1, 9)); len_2 = CNT_W'($urandom_range(1, 9));
    len_3 = CNT_W'($urandom_range(1, 9)); cont_mode = 1'($urandom);

    if (total == 0) begin
      @(negedge aclk);
      chk("zero_done", 32'(done), 1);
      chk("zero_busy", 32'(busy), 0);
      chk("zero_mtvalid", 32'(m_tvalid), 0);
      frame_exp++;
      @(negedge aclk);
      chk("zero_done_once", 32'(done), 0);
      chk_frames();
      return;
    end

    idx = 0; cyc = 0; pend = 1'b0; stop_sent = 1'b0;
    while (1) begin
      s_tvalid = (vmode == 0) ? 1'b1 : 1'($urandom);
      m_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom);
      stop = 1'b0;
      if (cm && !stop_sent && idx == (nseq - 1) * seqlen) begin
        stop = 1'b1; stop_sent = 1'b1;
      end
      if (idx == abort_at) begin
        abort = 1'b1; s_tvalid = 1'b0;
      end
      if (idx == reset_at) begin
        #1 areset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sel", 32'(demux_sel), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_mtvalid", 32'(m_tvalid), 0);
        chk("arst_stready", 32'(s_tready), 0);
        frame_exp = 0;
        chk_frames();
        areset = 1'b0;
        stop = 1'b0;
        return;
      end
      @(negedge aclk);
      chk("done", 32'(done), 32'(pend));
      if (pend) frame_exp++;
      pend = 1'b0;
      if (idx < total) begin
        chk("busy", 32'(busy), 1);
        chk("sel", 32'(demux_sel), 32'(rt[idx]));
        chk("mtvalid", 32'(m_tvalid), 32'(s_tvalid));
        chk("stready", 32'(s_tready), 32'(m_tready));
        if (abort) begin
          @(posedge aclk); #1;
          abort = 1'b0; m_tready = 1'b1; s_tvalid = 1'b1; stop = 1'b0;
          @(negedge aclk);
          chk("abort_busy", 32'(busy), 0);
          chk("abort_done", 32'(done), 0);
          chk("abort_stready", 32'(s_tready), 0);
          chk("abort_sel", 32'(demux_sel), 0);
          chk_frames();
          return;
        end
        if (s_tvalid && m_tready) begin
          idx++;
          if (idx % seqlen == 0) pend = 1'b1;
        end
      end else begin
        chk("end_busy", 32'(busy), 0);
        chk("end_sel", 32'(demux_sel), 0);
        chk("end_mtvalid", 32'(m_tvalid), 0);
        chk_frames();
        break;
      end
      cyc++;
      if (cyc > 3000) begin
        chk("timeout", 0, 1);
        break;
      end
      @(posedge aclk); #1;
    end
    stop = 1'b0;
  endtask

  initial begin
    areset = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0; cont_mode = 1'b0;
    len_1 = '0; len_2 = '0; len_3 = '0; s_tvalid = 1'b1; m_tready = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sel", 32'(demux_sel), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mtvalid", 32'(m_tvalid), 0);
    chk("rst_stready", 32'(s_tready), 0);
    chk_frames();
    repeat (2) @(negedge aclk);
    areset = 1'b0;

    run(3, 2, 4, 1'b0, 1, 0, 0, -1, -1);
    run(0, 5, 0, 1'b0, 1, 0, 0, -1, -1);
    run(1, 1, 1, 1'b1, 2, 0, 0, -1, -1);
    run(2, 2, 2, 1'b0, 1, 1, 0, -1, -1);
    run(2, 3, 2, 1'b0, 1, 0, 0, 3, -1);
    run(2, 3, 2, 1'b0, 1, 2, 1, -1, -1);
    run(0, 0, 0, 1'b0, 1, 0, 0, -1, -1);
    for (int t = 0; t < 25; t++) begin
      int ra, rb, rc, rn;
      bit rcm;
      ra = $urandom_range(0, 4); rb = $urandom_range(0, 4); rc = $urandom_range(0, 4);
      rcm = 1'($urandom); rn = $urandom_range(1, 3);
      run(ra, rb, rc, rcm, rn, 2, 1, -1, -1);
    end
    run(3, 2, 4, 1'b0, 1, 0, 0, -1, 6);
    run(1, 2, 1, 1'b0, 1, 0, 0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
